// File: rtl/camctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camctrl_pkg
// Description : Shared constants for the camera command controller: control
//               register bit positions, one-hot FSM encoding, status indices.
// Revision    : 1.0  initial release
// ============================================================================
package camctrl_pkg;

  // Command bit positions inside reg_camera_control
  localparam int TRAIN_BIT = 3;
  localparam int GRAB_BIT  = 4;
  localparam int TEMP_BIT  = 6;
  localparam int ABORT_BIT = 7;

  // One-hot state bit positions
  localparam int ST_IDLE_IDX      = 0;
  localparam int ST_TRAIN_IDX     = 1;
  localparam int ST_GRAB_IDX      = 2;
  localparam int ST_TEMP_SEL_IDX  = 3;
  localparam int ST_TEMP_WAIT_IDX = 4;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_TRAIN     = 5'b00010,
    ST_GRAB      = 5'b00100,
    ST_TEMP_SEL  = 5'b01000,
    ST_TEMP_WAIT = 5'b10000
  } state_e;

  // Status word bit positions
  localparam int STAT_TRAIN_ACTIVE = 0;
  localparam int STAT_TEMP_ACTIVE  = 1;
  localparam int STAT_ABORT_SEEN   = 2;
  localparam int STAT_TIMEOUT_ERR  = 3;

endpackage : camctrl_pkg
`default_nettype wire

// File: rtl/camctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : camctrl_edge_det
// Description : Rising-edge detector with an optional 2-flop synchronizer in
//               front (SYNC_STAGES = 0 or 2). The previous-value register is
//               updated every cycle; rise is combinational.
// Revision    : 1.0  initial release
// ============================================================================
module camctrl_edge_det #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;

  generate
    if (SYNC_STAGES == 2) begin : g_sync
      logic [WIDTH-1:0] meta_q;
      logic [WIDTH-1:0] sync_q;

      // Two-flop synchronizer for inputs from foreign timing domains
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= d;
          sync_q <= meta_q;
        end
      end

      assign level = sync_q;
    end else begin : g_direct
      assign level = d;
    end
  endgenerate

  // Previous-cycle copy of the (possibly synchronized) level
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule : camctrl_edge_det
`default_nettype wire

// File: rtl/camera_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : camera_ctrl_seq
// Description : Camera command sequencer. Edge-detects software command bits
//               and runs sensor training, frame-burst grab and per-channel
//               temperature SPI reads; sticky supply2 enable on SPI write.
//               Optional watchdog on TRAIN / TEMP_WAIT when the macro
//               CAMCTRL_TIMEOUT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module camera_ctrl_seq
  import camctrl_pkg::*;
#(
  parameter int CTRL_W  = 8,
  parameter int BURST_W = 8,
  parameter int N_TEMP  = 2,
  parameter int TMO_W   = 20
) (
  input  logic                clk_fix,
  input  logic                rst_fix,
  input  logic [CTRL_W-1:0]   reg_camera_control,
  input  logic [BURST_W-1:0]  reg_burst_len,
  input  logic [N_TEMP-1:0]   reg_temp_mask,
  input  logic [TMO_W-1:0]    reg_timeout,
  input  logic                training_done,
  input  logic                temp_done,
  input  logic                spi_write,
  output logic                cmd_start_training,
  output logic                frame_req,
  output logic [N_TEMP-1:0]   CS_n,
  output logic                FPGA_EN,
  output logic                busy,
  output logic [3:0]          status
);

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  logic [CTRL_W-1:0] ctrl_rise;
  logic [0:0]        tdone_rise;
  logic [1:0]        sync_in_rise;

  camctrl_edge_det #(.WIDTH(CTRL_W), .SYNC_STAGES(0)) u_ctrl_edge (
    .clk  (clk_fix),
    .rst  (rst_fix),
    .d    (reg_camera_control),
    .rise (ctrl_rise)
  );

  camctrl_edge_det #(.WIDTH(1), .SYNC_STAGES(2)) u_tdone_edge (
    .clk  (clk_fix),
    .rst  (rst_fix),
    .d    (training_done),
    .rise (tdone_rise)
  );

  camctrl_edge_det #(.WIDTH(2), .SYNC_STAGES(0)) u_spi_edge (
    .clk  (clk_fix),
    .rst  (rst_fix),
    .d    ({spi_write, temp_done}),
    .rise (sync_in_rise)
  );

  logic train_rise, grab_rise, temp_rise, abort_rise;
  logic train_done_rise, temp_done_rise, spi_rise;

  assign train_rise      = ctrl_rise[TRAIN_BIT];
  assign grab_rise       = ctrl_rise[GRAB_BIT];
  assign temp_rise       = ctrl_rise[TEMP_BIT];
  assign abort_rise      = ctrl_rise[ABORT_BIT];
  assign train_done_rise = tdone_rise[0];
  assign temp_done_rise  = sync_in_rise[0];
  assign spi_rise        = sync_in_rise[1];

  // Control bits without a command meaning are edge-detected but ignored
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_rise;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic               cmd_q, cmd_d;
  logic               frame_q, frame_d;
  logic [N_TEMP-1:0]  cs_n_q, cs_n_d;
  logic               fpga_en_q, fpga_en_d;
  logic               abort_seen_q, abort_seen_d;
  logic               timeout_err_q, timeout_err_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [N_TEMP-1:0]  mask_q, mask_d;
  logic               timeout_hit;

  // Lowest set bit of the pending sensor mask, as a one-hot vector
  function automatic logic [N_TEMP-1:0] lowest_set(input logic [N_TEMP-1:0] m);
    logic [N_TEMP-1:0] r;
    r = '0;
    for (int i = N_TEMP - 1; i >= 0; i--) begin
      if (m[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Optional watchdog
  // --------------------------------------------------------------------------
`ifdef CAMCTRL_TIMEOUT_EN
  logic [TMO_W-1:0] wd_q, wd_d;

  // Count cycles spent in a waiting state; restart whenever the state changes
  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_TRAIN) || (state_q == ST_TEMP_WAIT))) begin
      wd_d = wd_q + TMO_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // wd_q holds (cycles already spent - 1) on the deciding edge, so the exit
  // lands exactly reg_timeout cycles after entry
  assign timeout_hit = (reg_timeout != '0) && (wd_q == (reg_timeout - TMO_W'(1)));
`else
  logic unused_tmo;
  assign unused_tmo  = ^reg_timeout;
  assign timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  logic [N_TEMP-1:0] sel;

  // Sequencer: abort overrides everything, IDLE arbitrates temp > grab > train
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    frame_d       = frame_q;
    cs_n_d        = cs_n_q;
    fpga_en_d     = fpga_en_q;
    abort_seen_d  = abort_seen_q;
    timeout_err_d = timeout_err_q;
    burst_d       = burst_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q;
    sel           = '0;

    // Supply enable is independent of the sequencer and survives aborts
    if (spi_rise) begin
      fpga_en_d = 1'b1;
    end

    if (abort_rise) begin
      state_d      = ST_IDLE;
      cmd_d        = 1'b0;
      frame_d      = 1'b0;
      cs_n_d       = '1;
      abort_seen_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (temp_rise) begin
            // A temperature request with nothing enabled is silently dropped
            if (reg_temp_mask != '0) begin
              mask_d        = reg_temp_mask;
              state_d       = ST_TEMP_SEL;
              abort_seen_d  = 1'b0;
              timeout_err_d = 1'b0;
            end
          end else if (grab_rise) begin
            burst_d       = (reg_burst_len == '0) ? BURST_W'(1) : reg_burst_len;
            frame_d       = 1'b1;
            cnt_d         = BURST_W'(1);
            state_d       = ST_GRAB;
            abort_seen_d  = 1'b0;
            timeout_err_d = 1'b0;
          end else if (train_rise) begin
            cmd_d         = 1'b1;
            state_d       = ST_TRAIN;
            abort_seen_d  = 1'b0;
            timeout_err_d = 1'b0;
          end
        end

        ST_TRAIN: begin
          if (train_done_rise) begin
            cmd_d   = 1'b0;
            state_d = ST_IDLE;
          end else if (timeout_hit) begin
            cmd_d         = 1'b0;
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
          end
        end

        ST_GRAB: begin
          // cnt counts frame_req cycles already issued; it never exceeds burst
          if (cnt_q == burst_q) begin
            frame_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + BURST_W'(1);
          end
        end

        ST_TEMP_SEL: begin
          sel     = lowest_set(mask_q);
          cs_n_d  = ~sel;
          mask_d  = mask_q & ~sel;
          state_d = ST_TEMP_WAIT;
        end

        ST_TEMP_WAIT: begin
          // Passing back through TEMP_SEL gives the gap cycle between sensors
          if (temp_done_rise) begin
            cs_n_d  = '1;
            state_d = (mask_q != '0) ? ST_TEMP_SEL : ST_IDLE;
          end else if (timeout_hit) begin
            cs_n_d        = '1;
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cmd_d   = 1'b0;
          frame_d = 1'b0;
          cs_n_d  = '1;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      state_q       <= ST_IDLE;
      cmd_q         <= 1'b0;
      frame_q       <= 1'b0;
      cs_n_q        <= '1;
      fpga_en_q     <= 1'b0;
      abort_seen_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      burst_q       <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      frame_q       <= frame_d;
      cs_n_q        <= cs_n_d;
      fpga_en_q     <= fpga_en_d;
      abort_seen_q  <= abort_seen_d;
      timeout_err_q <= timeout_err_d;
      burst_q       <= burst_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_start_training = cmd_q;
  assign frame_req          = frame_q;
  assign CS_n               = cs_n_q;
  assign FPGA_EN            = fpga_en_q;
  assign busy               = (state_q != ST_IDLE);

  assign status[STAT_TRAIN_ACTIVE] = (state_q == ST_TRAIN);
  assign status[STAT_TEMP_ACTIVE]  = (state_q == ST_TEMP_SEL) || (state_q == ST_TEMP_WAIT);
  assign status[STAT_ABORT_SEEN]   = abort_seen_q;
  assign status[STAT_TIMEOUT_ERR]  = timeout_err_q;

endmodule : camera_ctrl_seq
`default_nettype wire

// File: tb/tb_camera_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_ctrl_seq
// Description : Self-checking bench for camera_ctrl_seq. Expected values come
//               from a behavioural model: burst length -> frame_req cycle
//               count, mask -> ordered list of chip-select patterns.
// Revision    : 1.0  initial release
// ============================================================================
module tb_camera_ctrl_seq;

  localparam int CTRL_W  = 8;
  localparam int BURST_W = 8;
  localparam int NT      = 2;
  localparam int TMO_W   = 20;

  logic              clk_fix = 1'b0;
  logic              rst_fix;
  logic [CTRL_W-1:0] ctrl;
  logic [BURST_W-1:0] burst_len;
  logic [NT-1:0]     temp_mask;
  logic [TMO_W-1:0]  tmo;
  logic              training_done, temp_done, spi_write;
  logic              cmd_start_training, frame_req, FPGA_EN, busy;
  logic [NT-1:0]     CS_n;
  logic [3:0]        status;

  int checks = 0;
  int errors = 0;

  camera_ctrl_seq #(
    .CTRL_W(CTRL_W), .BURST_W(BURST_W), .N_TEMP(NT), .TMO_W(TMO_W)
  ) dut (
    .clk_fix            (clk_fix),
    .rst_fix            (rst_fix),
    .reg_camera_control (ctrl),
    .reg_burst_len      (burst_len),
    .reg_temp_mask      (temp_mask),
    .reg_timeout        (tmo),
    .training_done      (training_done),
    .temp_done          (temp_done),
    .spi_write          (spi_write),
    .cmd_start_training (cmd_start_training),
    .frame_req          (frame_req),
    .CS_n               (CS_n),
    .FPGA_EN            (FPGA_EN),
    .busy               (busy),
    .status             (status)
  );

  always #25 clk_fix = ~clk_fix;

  initial begin
    #(50 * 50000);
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  // Advance one clock; inputs driven and outputs sampled 5 units after the edge
  task automatic cyc();
    @(posedge clk_fix);
    #5;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise command bits for one cycle; returns just after the accepting edge
  task automatic pulse(input logic [CTRL_W-1:0] bits);
    ctrl = ctrl | bits;
    cyc();
    ctrl = ctrl & ~bits;
  endtask

  // Grab: frame_req and busy must both be high for max(len,1) cycles
  task automatic run_grab(input int len);
    int exp_n, nf, nb, n;
    exp_n = (len == 0) ? 1 : len;
    burst_len = BURST_W'(len);
    pulse(8'h10);
    nf = 0; nb = 0; n = 0;
    while ((frame_req === 1'b1 || busy === 1'b1) && n < 400) begin
      nf += int'(frame_req);
      nb += int'(busy);
      n++;
      cyc();
    end
    chk($sformatf("grab_frame_cycles_len%0d", len), nf, exp_n);
    chk($sformatf("grab_busy_cycles_len%0d", len), nb, exp_n);
  endtask

  // Temperature read: one CS_n stage per set mask bit, lowest bit first
  task automatic run_temp(input logic [NT-1:0] mask, input logic [CTRL_W-1:0] bits);
    logic [NT-1:0] exp_cs;
    int            remaining;
    temp_mask = mask;
    pulse(bits);
    chk("temp_start_busy", busy, 1);
    chk("temp_start_no_frame", frame_req, 0);
    chk("temp_start_no_train", cmd_start_training, 0);
    chk("temp_start_status", status, 4'b0010);
    chk("temp_start_cs_idle", CS_n, {NT{1'b1}});
    remaining = $countones(mask);
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        exp_cs    = '1;
        exp_cs[i] = 1'b0;
        cyc();
        chk($sformatf("temp_cs_sel%0d", i), CS_n, exp_cs);
        repeat ($urandom_range(1, 6)) cyc();
        chk($sformatf("temp_cs_hold%0d", i), CS_n, exp_cs);
        temp_done = 1'b1;
        cyc();
        temp_done = 1'b0;
        remaining--;
        chk($sformatf("temp_cs_release%0d", i), CS_n, {NT{1'b1}});
        chk($sformatf("temp_busy_after%0d", i), busy, (remaining != 0) ? 1 : 0);
      end
    end
  endtask

  // Training: cmd falls on the third edge after training_done goes high
  task automatic run_train(input int gap);
    pulse(8'h08);
    chk("train_cmd_on", cmd_start_training, 1);
    chk("train_status", status, 4'b0001);
    repeat (gap - 1) cyc();
    training_done = 1'b1;
    cyc();
    cyc();
    chk("train_cmd_held_2cyc", cmd_start_training, 1);
    cyc();
    chk("train_cmd_off_3cyc", cmd_start_training, 0);
    chk("train_busy_off", busy, 0);
    training_done = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    int n, len;
    rst_fix = 1'b1;
    ctrl = '0; burst_len = '0; temp_mask = '0; tmo = '0;
    training_done = 1'b0; temp_done = 1'b0; spi_write = 1'b0;
    repeat (3) cyc();

    // Reset values
    chk("rst_cmd", cmd_start_training, 0);
    chk("rst_frame", frame_req, 0);
    chk("rst_cs", CS_n, {NT{1'b1}});
    chk("rst_fpga_en", FPGA_EN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status", status, 0);
    rst_fix = 1'b0;
    cyc();

    // Grab: directed boundaries then random lengths
    run_grab(11);
    run_grab(0);
    run_grab(1);
    run_grab(255);
    for (int k = 0; k < 6; k++) run_grab($urandom_range(0, 40));

    // Training
    run_train(50);
    run_train($urandom_range(5, 80));

    // Temperature
    run_temp(2'b11, 8'h40);
    for (int k = 0; k < 4; k++) run_temp(NT'($urandom_range(1, 3)), 8'h40);
    temp_mask = '0;
    pulse(8'h40);
    n = 0;
    repeat (5) begin
      n += int'(busy);
      cyc();
    end
    chk("temp_zero_mask_busy", n, 0);

    // Simultaneous rises: temperature wins
    run_temp(2'b01, 8'h58);
    chk("simul_no_frame_after", frame_req, 0);
    chk("simul_no_train_after", cmd_start_training, 0);

    // Rise during a grab is dropped, not queued
    burst_len = 8'd20;
    pulse(8'h10);
    n = 0;
    repeat (3) begin
      n += int'(frame_req);
      cyc();
    end
    ctrl[3] = 1'b1;
    n += int'(frame_req);
    cyc();
    ctrl[3] = 1'b0;
    while (frame_req === 1'b1 && n < 400) begin
      n++;
      cyc();
    end
    chk("drop_grab_len", n, 20);
    repeat (3) cyc();
    chk("drop_no_train", cmd_start_training, 0);
    chk("drop_idle", busy, 0);

    // Abort mid-grab when cnt reaches 5
    len = $urandom_range(10, 40);
    burst_len = BURST_W'(len);
    pulse(8'h10);
    repeat (4) cyc();
    chk("abort_frame_before", frame_req, 1);
    pulse(8'h80);
    chk("abort_frame_low", frame_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_status", status, 4'b0100);
    run_grab(3);
    chk("abort_seen_cleared", status[2], 0);

    // Supply enable during training survives abort
    pulse(8'h08);
    chk("supply_before", FPGA_EN, 0);
    spi_write = 1'b1;
    cyc();
    spi_write = 1'b0;
    chk("supply_set", FPGA_EN, 1);
    chk("supply_train_kept", cmd_start_training, 1);
    pulse(8'h80);
    chk("supply_abort_cmd", cmd_start_training, 0);
    chk("supply_abort_seen", status, 4'b0100);
    repeat (5) cyc();
    chk("supply_sticky", FPGA_EN, 1);

`ifdef CAMCTRL_TIMEOUT_EN
    tmo = 20'd100;
    pulse(8'h08);
    n = 0;
    while (cmd_start_training === 1'b1 && n < 300) begin
      n++;
      cyc();
    end
    chk("tmo_train_cycles", n, 100);
    chk("tmo_status", status, 4'b1000);
    tmo = '0;
    pulse(8'h08);
    chk("tmo_err_cleared", status[3], 0);
    repeat (150) cyc();
    chk("tmo_disabled_hold", cmd_start_training, 1);
    pulse(8'h80);
`else
    tmo = 20'd100;
    pulse(8'h08);
    repeat (150) cyc();
    chk("notmo_train_hold", cmd_start_training, 1);
    chk("notmo_status3", status[3], 0);
    pulse(8'h80);
    chk("notmo_abort_exit", busy, 0);
`endif

    // Reset mid-operation
    burst_len = 8'd50;
    pulse(8'h10);
    repeat (3) cyc();
    rst_fix = 1'b1;
    cyc();
    chk("midrst_frame", frame_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fpga_en", FPGA_EN, 0);
    chk("midrst_cs", CS_n, {NT{1'b1}});
    chk("midrst_status", status, 0);
    rst_fix = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_camera_ctrl_seq
`default_nettype wire
